data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 113 +++++++++++
 tb/tb_data_mem_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory controller: it stalls the pipeline for LATENCY+1 cycles per
// access and then pulses ack_o for one cycle.
module data_mem_ctrl #(
  parameter int LATENCY    = 3,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic [1:0]  state_dbg_o
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  // Handshake: MemRead_i/MemWrite_i are levels that stay high while stall_o=1.
  // An access starts in any IDLE cycle that sees a request. It then freezes the
  // pipeline through BUSY and completes with a single ack_o cycle (DONE). During
  // DONE stall_o is low, so the same instruction advances; its requests are ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic                    is_write_q;
  logic [31:0]             mem [WORDS];
  logic                    req;
  logic                    stall_c, ack_c;
  logic                    unused_addr;

  assign req         = MemRead_i | MemWrite_i;
  assign unused_addr = ^{address_i[1:0], address_i[31:DEPTH_LOG2+2]};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    ack_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall_c = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (cnt_q == 4'd0) state_d = DONE;
      end
      DONE: begin
        ack_c   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset dominates the combinational outputs so a held request cannot freeze the pipe.
    if (rst_i) begin
      stall_c = 1'b0;
      ack_c   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      wdata_q     <= 32'd0;
      is_write_q  <= 1'b0;
      read_data_o <= 32'd0;
      for (int i = 0; i < WORDS; i++) mem[i] <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            // A simultaneous read and write resolves to a write.
            idx_q      <= address_i[DEPTH_LOG2+1:2];
            wdata_q    <= write_data_i;
            is_write_q <= MemWrite_i;
            cnt_q      <= 4'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            if (is_write_q) mem[idx_q]  <= wdata_q;
            else            read_data_o <= mem[idx_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_o     = stall_c;
  assign ack_o       = ack_c;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: instance u0 runs at LATENCY=3 and u1 at LATENCY=1.
// Expected values are hand-computed constants.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        rd0, wr0, rd1, wr1;
  logic [31:0] addr0, wd0, addr1, wd1;
  logic [31:0] rdata0, rdata1;
  logic        stall0, stall1, ack0, ack1;
  logic [1:0]  st0, st1;
  int          cyc;
  int          checks;
  int          failures;

  data_mem_ctrl #(.LATENCY(3), .DEPTH_LOG2(5)) u0 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd0), .MemWrite_i(wr0),
    .address_i(addr0), .write_data_i(wd0), .read_data_o(rdata0),
    .stall_o(stall0), .ack_o(ack0), .state_dbg_o(st0)
  );

  data_mem_ctrl #(.LATENCY(1), .DEPTH_LOG2(5)) u1 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd1), .MemWrite_i(wr1),
    .address_i(addr1), .write_data_i(wd1), .read_data_o(rdata1),
    .stall_o(stall1), .ack_o(ack1), .state_dbg_o(st1)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel == 0) begin rd0 = rd; wr0 = wr; addr0 = addr; wd0 = data; end
    else          begin rd1 = rd; wr1 = wr; addr1 = addr; wd1 = data; end
  endtask

  // Starts an access in the current cycle. It holds the request until ack or
  // timeout, scrambles address and data while busy, and returns the stall count,
  // ack offset, absolute ack cycle and read data. It exits #1 after the edge that
  // follows the ack cycle.
  task automatic access(input int sel, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        output int n_stall, output int ack_at, output int ack_cyc,
                        output logic [31:0] rdata);
    logic s, a;
    n_stall = 0; ack_at = -1; ack_cyc = -1; rdata = 32'hxxxx_xxxx;
    drive(sel, rd, wr, addr, data);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      s = (sel == 0) ? stall0 : stall1;
      a = (sel == 0) ? ack0 : ack1;
      if (s) n_stall++;
      if (a && ack_at < 0) begin
        ack_at  = c;
        ack_cyc = cyc;
        rdata   = (sel == 0) ? rdata0 : rdata1;
      end
      @(posedge clk); #1;
      if (ack_at >= 0) break;
      drive(sel, rd, wr, ~addr, ~data);
    end
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  int          ns, at, ac, ac_prev;
  logic [31:0] rv;

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h10, 32'h1);
    drive(1, 1'b1, 1'b0, 32'h10, 32'h1);

    // Reset with requests high: outputs stay quiet
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall0", 32'(stall0), 32'd0);
    check("rst_ack0",   32'(ack0),   32'd0);
    check("rst_stall1", 32'(stall1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    check("rst_rdata", rdata0, 32'd0);
    check("rst_state", 32'(st0), 32'd0);

    // Write 0xDEADBEEF to 0x10: stall in cycles 0-3, ack in cycle 4
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ns, at, ac, rv);
    check("wr_stall_cycles", 32'(ns), 32'd4);
    check("wr_ack_at",       32'(at), 32'd4);
    check("wr_rdata_hold",   rv,      32'd0);

    // Read back, including a misaligned alias of the same word
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, ns, at, ac, rv);
    check("rd10_ack_at", 32'(at), 32'd4);
    check("rd10_stall",  32'(ns), 32'd4);
    check("rd10_data",   rv,      32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 32'h13, 32'h0, ns, at, ac, rv);
    check("rd13_data", rv, 32'hDEADBEEF);

    // Both requests high resolve to a write; read data holds its last value
    access(0, 1'b1, 1'b1, 32'h08, 32'h12345678, ns, at, ac, rv);
    check("both_ack_at", 32'(at), 32'd4);
    check("both_rdata_hold", rv, 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 32'h08, 32'h0, ns, at, ac, rv);
    check("both_rd08", rv, 32'h12345678);

    // Out-of-range address bits alias: 0x84 maps to word 1
    access(0, 1'b0, 1'b1, 32'h84, 32'h99, ns, at, ac, rv);
    access(0, 1'b1, 1'b0, 32'h04, 32'h0, ns, at, ac, rv);
    check("alias_rd04", rv, 32'h99);

    // Back-to-back write then read of the same word
    access(0, 1'b0, 1'b1, 32'h1C, 32'hA5A5_5A5A, ns, at, ac, rv);
    ac_prev = ac;
    access(0, 1'b1, 1'b0, 32'h1C, 32'h0, ns, at, ac, rv);
    check("b2b_rd1c", rv, 32'hA5A5_5A5A);
    check("b2b_ack_gap", 32'(ac - ac_prev), 32'd5);

    // Reset in the second BUSY cycle aborts a write to 0x04
    drive(0, 1'b0, 1'b1, 32'h04, 32'h55);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_stall_in_rst", 32'(stall0), 32'd0);
    check("abort_ack_in_rst",   32'(ack0),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("abort_stall_next", 32'(stall0), 32'd0);
    check("abort_ack_next",   32'(ack0),   32'd0);
    check("abort_state",      32'(st0),    32'd0);
    check("abort_rdata_clr",  rdata0,      32'd0);
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 32'h04, 32'h0, ns, at, ac, rv);
    check("abort_rd04", rv, 32'd0);
    check("abort_rd04_ack_at", 32'(at), 32'd4);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, ns, at, ac, rv);
    check("rst_cleared_rd10", rv, 32'd0);

    // Request already present in the first cycle after reset is accepted
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h08, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    access(0, 1'b1, 1'b0, 32'h08, 32'h0, ns, at, ac, rv);
    check("first_after_rst_ack_at", 32'(at), 32'd4);
    check("first_after_rst_stall",  32'(ns), 32'd4);

    // LATENCY=1: two writes then two back-to-back reads
    access(1, 1'b0, 1'b1, 32'h00, 32'h0000_0111, ns, at, ac, rv);
    check("l1_wr_stall",  32'(ns), 32'd2);
    check("l1_wr_ack_at", 32'(at), 32'd2);
    access(1, 1'b0, 1'b1, 32'h04, 32'h0000_0222, ns, at, ac, rv);
    access(1, 1'b1, 1'b0, 32'h00, 32'h0, ns, at, ac, rv);
    check("l1_rd0_stall", 32'(ns), 32'd2);
    check("l1_rd0_data",  rv,      32'h0000_0111);
    ac_prev = ac;
    access(1, 1'b1, 1'b0, 32'h04, 32'h0, ns, at, ac, rv);
    check("l1_rd1_stall", 32'(ns), 32'd2);
    check("l1_rd1_data",  rv,      32'h0000_0222);
    check("l1_ack_gap",   32'(ac - ac_prev), 32'd3);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
